addsub_pipe: RTL and testbench

Parametrised, pipelined two's-complement adder/subtractor for the datapath. It is the multi-bit successor to the single-bit XOR3 sum cell: sum bit = A ^ B ^ Sub-driven carry-in, with subtraction as A + ~B + 1. The carry chain is split into STAGES registered segments so wide operands meet timing. A valid/ready handshake on each side lets the block stall without losing operands.

---
 rtl/addsub_pkg.sv | 28 ++
 rtl/addsub_slice.sv | 33 +++
 rtl/addsub_pipe.sv | 172 +++++++++++++++++
 tb/tb_addsub_pipe.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// Shared types and saturation helpers for the pipelined adder/subtractor.
// Saturation helpers are only referenced when ADDSUB_SAT_EN is defined.
package addsub_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } addsub_op_e;

    localparam int SAT_MAX_W = 64;

    function automatic logic [SAT_MAX_W-1:0] sat_max(input int w);
        logic [SAT_MAX_W-1:0] r;
        r = '0;
        for (int i = 0; i < w - 1; i++) begin
            r[i] = 1'b1;
        end
        return r;
    endfunction

    function automatic logic [SAT_MAX_W-1:0] sat_min(input int w);
        logic [SAT_MAX_W-1:0] r;
        r = '0;
        r[w-1] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/addsub_slice.sv
// Combinational ripple segment: sum = a + (b ^ sub) + cin, built from XOR3 sum cells.
// msb_carry_in is the carry entering the top bit, used for signed overflow.
module addsub_slice #(
    parameter int SEG_W = 8
) (
    input  logic [SEG_W-1:0] a,
    input  logic [SEG_W-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic [SEG_W-1:0] sum,
    output logic             cout,
    output logic             msb_carry_in
);

    always_comb begin : ripple
        logic c;
        logic bx;
        c            = cin;
        bx           = 1'b0;
        sum          = '0;
        msb_carry_in = 1'b0;
        for (int i = 0; i < SEG_W; i++) begin
            bx = b[i] ^ sub;
            if (i == SEG_W - 1) begin
                msb_carry_in = c;
            end
            sum[i] = a[i] ^ bx ^ c;
            c      = (a[i] & bx) | (a[i] & c) | (bx & c);
        end
        cout = c;
    end

endmodule

// File: rtl/addsub_pipe.sv
// Pipelined two's-complement adder/subtractor, carry chain split into STAGES registered segments.
// Define ADDSUB_SAT_EN to clamp Y to the signed limits on overflow (Ovf/Cout stay unsaturated).
module addsub_pipe
    import addsub_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             In_valid,
    output logic             In_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Sub,
    output logic             Out_valid,
    input  logic             Out_ready,
    output logic [WIDTH-1:0] Y,
    output logic             Cout,
    output logic             Ovf
);

    localparam int SEG = WIDTH / STAGES;

    logic [SEG-1:0] sl_a   [STAGES];
    logic [SEG-1:0] sl_b   [STAGES];
    logic [SEG-1:0] sl_sum [STAGES];
    logic           sl_sub [STAGES];
    logic           sl_cin [STAGES];
    logic           sl_cout[STAGES];
    logic           sl_msbc[STAGES];

    logic             adv;
    addsub_op_e       op_in;
    logic             last_vld;
    logic [WIDTH-1:0] y_raw;
    logic [WIDTH-1:0] y_d;
    logic             ovf_d;

    logic             out_vld_q;
    logic [WIDTH-1:0] y_q;
    logic             cout_q;
    logic             ovf_q;

    // The whole pipeline moves together; a held result blocks every stage.
    assign adv      = Out_ready || !out_vld_q;
    assign In_ready = adv;

    assign op_in     = addsub_op_e'(Sub);
    assign sl_a[0]   = A[SEG-1:0];
    assign sl_b[0]   = B[SEG-1:0];
    assign sl_sub[0] = (op_in == OP_SUB);
    assign sl_cin[0] = (op_in == OP_SUB);

    genvar s;
    for (s = 0; s < STAGES; s++) begin : g_slice
        addsub_slice #(.SEG_W(SEG)) u_slice (
            .a            (sl_a[s]),
            .b            (sl_b[s]),
            .sub          (sl_sub[s]),
            .cin          (sl_cin[s]),
            .sum          (sl_sum[s]),
            .cout         (sl_cout[s]),
            .msb_carry_in (sl_msbc[s])
        );
    end

    // Stage k holds the low (k+1) result segments plus the operand bits still to be summed.
    genvar k;
    for (k = 0; k < STAGES - 1; k++) begin : g_mid
        localparam int REST = WIDTH - (k + 1) * SEG;
        localparam int LOW  = (k + 1) * SEG;

        logic            vld_q;
        logic            sub_q;
        logic            cy_q;
        logic [REST-1:0] a_rest_q;
        logic [REST-1:0] b_rest_q;
        logic [LOW-1:0]  psum_q;

        logic            vld_d;
        logic            sub_d;
        logic [REST-1:0] a_rest_d;
        logic [REST-1:0] b_rest_d;
        logic [LOW-1:0]  psum_d;

        if (k == 0) begin : g_src_port
            assign vld_d    = In_valid;
            assign sub_d    = (op_in == OP_SUB);
            assign a_rest_d = A[WIDTH-1:SEG];
            assign b_rest_d = B[WIDTH-1:SEG];
            assign psum_d   = sl_sum[0];
        end else begin : g_src_mid
            assign vld_d    = g_mid[k-1].vld_q;
            assign sub_d    = g_mid[k-1].sub_q;
            assign a_rest_d = g_mid[k-1].a_rest_q[REST+SEG-1:SEG];
            assign b_rest_d = g_mid[k-1].b_rest_q[REST+SEG-1:SEG];
            assign psum_d   = {sl_sum[k], g_mid[k-1].psum_q};
        end

        always_ff @(posedge Clk or posedge Rst) begin
            if (Rst) begin
                vld_q <= 1'b0;
            end else if (adv) begin
                vld_q <= vld_d;
            end
        end

        always_ff @(posedge Clk) begin
            if (adv) begin
                sub_q    <= sub_d;
                cy_q     <= sl_cout[k];
                a_rest_q <= a_rest_d;
                b_rest_q <= b_rest_d;
                psum_q   <= psum_d;
            end
        end

        assign sl_a[k+1]   = a_rest_q[SEG-1:0];
        assign sl_b[k+1]   = b_rest_q[SEG-1:0];
        assign sl_sub[k+1] = sub_q;
        assign sl_cin[k+1] = cy_q;
    end

    if (STAGES == 1) begin : g_single
        assign y_raw    = sl_sum[0];
        assign last_vld = In_valid;
    end else begin : g_multi
        assign y_raw    = {sl_sum[STAGES-1], g_mid[STAGES-2].psum_q};
        assign last_vld = g_mid[STAGES-2].vld_q;
    end

    // Carry into the MSB differing from carry out of it is exactly signed overflow.
    assign ovf_d = sl_msbc[STAGES-1] ^ sl_cout[STAGES-1];

`ifdef ADDSUB_SAT_EN
    localparam logic [WIDTH-1:0] SAT_MAX = WIDTH'(sat_max(WIDTH));
    localparam logic [WIDTH-1:0] SAT_MIN = WIDTH'(sat_min(WIDTH));

    // Overflow direction follows the sign of A: negative A can only overflow downwards.
    always_comb begin
        y_d = y_raw;
        if (ovf_d) begin
            y_d = sl_a[STAGES-1][SEG-1] ? SAT_MIN : SAT_MAX;
        end
    end
`else
    assign y_d = y_raw;
`endif

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            out_vld_q <= 1'b0;
            y_q       <= '0;
            cout_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else if (adv) begin
            out_vld_q <= last_vld;
            if (last_vld) begin
                y_q    <= y_d;
                cout_q <= sl_cout[STAGES-1];
                ovf_q  <= ovf_d;
            end
        end
    end

    assign Out_valid = out_vld_q;
    assign Y         = y_q;
    assign Cout      = cout_q;
    assign Ovf       = ovf_q;

endmodule

// File: tb/tb_addsub_pipe.sv
// Self-checking bench for addsub_pipe: arithmetic reference model + scoreboard, directed corner cases.
// Honours ADDSUB_SAT_EN for expected Y values.
module tb_addsub_pipe;

    localparam int W = 16;
    localparam int S = 2;
`ifdef ADDSUB_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct packed {
        logic [W-1:0] y;
        logic         c;
        logic         o;
    } res_t;

    logic         Clk = 1'b0;
    logic         Rst;
    logic         In_valid;
    logic         In_ready;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Sub;
    logic         Out_valid;
    logic         Out_ready;
    logic [W-1:0] Y;
    logic         Cout;
    logic         Ovf;

    int   n_chk  = 0;
    int   n_fail = 0;
    res_t sb[$];
    int   got[$];
    bit   rec_en = 1'b0;

    addsub_pipe #(.WIDTH(W), .STAGES(S)) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .In_valid  (In_valid),
        .In_ready  (In_ready),
        .A         (A),
        .B         (B),
        .Sub       (Sub),
        .Out_valid (Out_valid),
        .Out_ready (Out_ready),
        .Y         (Y),
        .Cout      (Cout),
        .Ovf       (Ovf)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned and signed interpretations.
    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
        res_t   r;
        logic [W-1:0] nb;
        longint mask, ua, ub, unb, usum, sa, sb_, rs, smax, smin;
        mask = (longint'(1) << W) - 1;
        smax = (longint'(1) << (W - 1)) - 1;
        smin = -(longint'(1) << (W - 1));
        nb   = ~b;
        ua   = longint'(a);
        ub   = longint'(b);
        unb  = longint'(nb);
        usum = sub ? (ua + unb + 1) : (ua + ub);
        sa   = (ua > smax) ? ua - (mask + 1) : ua;
        sb_  = (ub > smax) ? ub - (mask + 1) : ub;
        rs   = sub ? (sa - sb_) : (sa + sb_);
        r.c  = ((usum >> W) & 1) != 0;
        r.o  = (rs > smax) || (rs < smin);
        r.y  = W'(usum & mask);
        if (SAT && r.o) begin
            r.y = (rs > smax) ? W'(smax) : W'(smin & mask);
        end
        return r;
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0: return '0;
            1: return W'(1);
            2: return W'(16'h7FFF);
            3: return W'(16'h8000);
            4: return '1;
            default: return W'($urandom);
        endcase
    endfunction

    // Scoreboard: sampled mid-cycle, where handshakes are stable before the next edge.
    always @(negedge Clk) begin : mon
        res_t e;
        if (Rst) begin
            sb.delete();
            chk("rst_in_ready", In_ready, 1);
        end else begin
            chk("in_ready_rule", In_ready, Out_ready || !Out_valid);
            if (Out_valid) begin
                if (sb.size() == 0) begin
                    chk("spurious_out_valid", Out_valid, 0);
                end else begin
                    e = sb[0];
                    chk("sb_y", Y, e.y);
                    chk("sb_cout", Cout, e.c);
                    chk("sb_ovf", Ovf, e.o);
                    if (Out_ready) begin
                        void'(sb.pop_front());
                        if (rec_en) got.push_back(int'(Y));
                    end
                end
            end
            if (In_valid && In_ready) sb.push_back(model(A, B, Sub));
        end
    end

    // Presents a beat from just after a rising edge; returns just after the edge that accepted it.
    task automatic drive_beat(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
        bit acc;
        bit ok;
        ok       = 1'b0;
        In_valid = 1'b1;
        A        = a;
        B        = b;
        Sub      = sub;
        for (int t = 0; t < 50; t++) begin
            @(negedge Clk);
            acc = In_ready;
            @(posedge Clk);
            #1;
            if (acc) begin
                ok = 1'b1;
                break;
            end
        end
        In_valid = 1'b0;
        if (!ok) chk("accept_timeout", 0, 1);
    endtask

    task automatic directed(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic sub, input logic [W-1:0] ey, input logic ec, input logic eo);
        int lat;
        drive_beat(a, b, sub);
        lat = 1;
        while (!Out_valid && lat < 20) begin
            @(posedge Clk);
            #1;
            lat++;
        end
        chk({nm, "_latency"}, lat, S);
        chk({nm, "_y"}, Y, ey);
        chk({nm, "_cout"}, Cout, ec);
        chk({nm, "_ovf"}, Ovf, eo);
        @(posedge Clk);
        #1;
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        bit acc;
        Rst       = 1'b1;
        In_valid  = 1'b0;
        Out_ready = 1'b1;
        A         = '0;
        B         = '0;
        Sub       = 1'b0;

        // Pin the model against hand-computed results.
        chk("pin_add_ovf", model(16'h7FFF, 16'h0001, 1'b0), {(SAT ? 16'h7FFF : 16'h8000), 1'b0, 1'b1});
        chk("pin_carry",   model(16'hFFFF, 16'h0001, 1'b0), {16'h0000, 1'b1, 1'b0});
        chk("pin_borrow",  model(16'h0005, 16'h0007, 1'b1), {16'hFFFE, 1'b0, 1'b0});
        chk("pin_neg_ovf", model(16'h8000, 16'h0001, 1'b1), {(SAT ? 16'h8000 : 16'h7FFF), 1'b1, 1'b1});

        @(posedge Clk);
        #1;
        chk("reset_out_valid", Out_valid, 0);
        chk("reset_y", Y, 0);
        chk("reset_cout", Cout, 0);
        chk("reset_ovf", Ovf, 0);
        chk("reset_in_ready", In_ready, 1);
        repeat (2) @(posedge Clk);
        #1;
        Rst = 1'b0;
        chk("post_reset_in_ready", In_ready, 1);

        directed("add_ovf", 16'h7FFF, 16'h0001, 1'b0, (SAT ? 16'h7FFF : 16'h8000), 1'b0, 1'b1);
        directed("carry",   16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        directed("borrow",  16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        directed("neg_ovf", 16'h8000, 16'h0001, 1'b1, (SAT ? 16'h8000 : 16'h7FFF), 1'b1, 1'b1);

        // Back-pressure: four beats, output stalled three cycles after the first result.
        got.delete();
        rec_en = 1'b1;
        fork
            begin
                for (int i = 1; i <= 4; i++) drive_beat(W'(i), W'(i), 1'b0);
            end
            begin
                for (int t = 0; t < 20 && !Out_valid; t++) begin
                    @(posedge Clk);
                    #1;
                end
                Out_ready = 1'b0;
                for (int st = 0; st < 3; st++) begin
                    @(negedge Clk);
                    chk("stall_in_ready", In_ready, 0);
                    chk("stall_y_held", Y, 16'h0002);
                    @(posedge Clk);
                    #1;
                end
                Out_ready = 1'b1;
            end
        join
        for (int t = 0; t < 30 && got.size() < 4; t++) begin
            @(posedge Clk);
            #1;
        end
        rec_en = 1'b0;
        chk("bp_count", got.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk("bp_order", (i < got.size()) ? got[i] : -1, 2 * (i + 1));
        end

        // Reset with two beats in flight.
        drive_beat(16'h0011, 16'h0001, 1'b0);
        drive_beat(16'h0022, 16'h0002, 1'b0);
        Rst = 1'b1;
        #1;
        chk("midrst_out_valid", Out_valid, 0);
        chk("midrst_y", Y, 0);
        chk("midrst_cout", Cout, 0);
        chk("midrst_ovf", Ovf, 0);
        chk("midrst_in_ready", In_ready, 1);
        repeat (2) @(posedge Clk);
        #1;
        Rst = 1'b0;
        for (int t = 0; t < 6; t++) begin
            @(negedge Clk);
            chk("no_stale_beat", Out_valid, 0);
        end
        @(posedge Clk);
        #1;
        directed("after_rst", 16'h0010, 16'h0020, 1'b0, 16'h0030, 1'b0, 1'b0);

        // Randomized traffic with random back-pressure, checked by the scoreboard.
        acc = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            Out_ready = ($urandom_range(0, 3) != 0);
            if (!In_valid || acc) begin
                In_valid = ($urandom_range(0, 4) != 0);
                A        = pick();
                B        = pick();
                Sub      = 1'($urandom_range(0, 1));
            end
            @(negedge Clk);
            acc = In_valid && In_ready;
            @(posedge Clk);
            #1;
        end
        In_valid  = 1'b0;
        Out_ready = 1'b1;
        for (int t = 0; t < 100 && (sb.size() != 0 || Out_valid); t++) begin
            @(posedge Clk);
            #1;
        end
        chk("drain_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
